// File: rtl/mem_wb_pipe_pkg.sv
// Shared types for the MEM/WB pipeline stage: load-size codes, occupancy
// states and default datapath widths.
package mem_wb_pipe_pkg;

   localparam logic [1:0] LD_B = 2'b00;
   localparam logic [1:0] LD_H = 2'b01;
   localparam logic [1:0] LD_W = 2'b10;
   localparam logic [1:0] LD_D = 2'b11;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_REG_AW = 5;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } occ_t;

   // Entry layout at the default widths; the stage re-declares it with its own widths.
   typedef struct packed {
      logic [DEF_DATA_W-1:0] data;
      logic [DEF_REG_AW-1:0] wn;
      logic                  we;
   } entry_t;

endpackage

// File: rtl/mem_wb_pipe_load_extend.sv
// Combinational load-data lane extraction with sign/zero extension.
// Usable by any path that turns a raw memory word into register data.
module load_extend
   import mem_wb_pipe_pkg::*;
#(
   parameter  int DATA_W = 32,
   localparam int LB     = $clog2(DATA_W/8)
) (
   input  logic [DATA_W-1:0] rd,
   input  logic [LB-1:0]     addr,
   input  logic [1:0]        size,
   input  logic              uns,
   output logic [DATA_W-1:0] data
);

   logic [7:0]  b;
   logic [15:0] h;
   logic [31:0] w;

   always_comb begin
      b = rd[8*int'(addr) +: 8];
      h = rd[16*int'(addr[LB-1:1]) +: 16];
      if (DATA_W == 64) w = rd[32*int'(addr[LB-1]) +: 32];
      else              w = rd[31:0];

      // On a 32-bit datapath a dword request falls through to the full word.
      case (size)
         LD_B:    data = uns ? DATA_W'(b) : DATA_W'($signed(b));
         LD_H:    data = uns ? DATA_W'(h) : DATA_W'($signed(h));
         LD_W:    data = uns ? DATA_W'(w) : DATA_W'($signed(w));
         default: data = rd;
      endcase
   end

endmodule

// File: rtl/mem_wb_pipe.sv
// MEM/WB pipeline stage: valid/ready handshake with a two-entry skid buffer,
// load extension before registering, flush, and a forwarding view of the head.
module mem_wb_pipe
   import mem_wb_pipe_pkg::*;
#(
   parameter int DATA_W        = DEF_DATA_W,
   parameter int REG_AW        = DEF_REG_AW,
   parameter bit ZERO_REG_HARD = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] rd_in,
   input  logic [DATA_W-1:0] alu_in,
   input  logic [REG_AW-1:0] wn_in,
   input  logic              reg_write_in,
   input  logic              mem_to_reg_in,
   input  logic [1:0]        ld_size_in,
   input  logic              ld_unsigned_in,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] wb_data,
   output logic [REG_AW-1:0] wb_wn,
   output logic              wb_we,
   output logic              fwd_valid,
   output logic [REG_AW-1:0] fwd_wn,
   output logic [DATA_W-1:0] fwd_data,
   output occ_t              state
);

   localparam int LB = $clog2(DATA_W/8);

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [REG_AW-1:0] wn;
      logic              we;
   } stage_entry_t;

   stage_entry_t in_entry, head, skid, head_d, skid_d;
   occ_t         state_d;
   logic [DATA_W-1:0] ext;
   logic         in_fire, out_fire;

   load_extend #(.DATA_W(DATA_W)) u_ext (
      .rd   (rd_in),
      .addr (alu_in[LB-1:0]),
      .size (ld_size_in),
      .uns  (ld_unsigned_in),
      .data (ext)
   );

   always_comb begin
      in_entry.data = mem_to_reg_in ? ext : alu_in;
      in_entry.wn   = wn_in;
      in_entry.we   = reg_write_in & ~(ZERO_REG_HARD && (wn_in == '0));
   end

   assign in_fire   = in_valid & in_ready;
   assign out_valid = (state != EMPTY);
   assign out_fire  = out_valid & out_ready;

   always_comb begin
      state_d = state;
      head_d  = head;
      skid_d  = skid;
      case (state)
         EMPTY: begin
            if (in_fire) begin
               state_d = ONE;
               head_d  = in_entry;
            end
         end
         ONE: begin
            if (in_fire && out_fire) begin
               head_d = in_entry;
            end else if (in_fire) begin
               state_d = TWO;
               skid_d  = in_entry;
            end else if (out_fire) begin
               state_d = EMPTY;
            end
         end
         TWO: begin
            if (out_fire) begin
               state_d = ONE;
               head_d  = skid;
            end
         end
         default: state_d = EMPTY;
      endcase
      // Flush wins over everything, including an input accepted this cycle.
      if (flush) state_d = EMPTY;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= EMPTY;
         head     <= '0;
         skid     <= '0;
         in_ready <= 1'b1;
      end else begin
         state    <= state_d;
         head     <= head_d;
         skid     <= skid_d;
         in_ready <= (state_d != TWO);
      end
   end

   assign wb_data   = out_valid ? head.data : '0;
   assign wb_wn     = out_valid ? head.wn   : '0;
   assign wb_we     = out_fire & head.we;
   assign fwd_valid = out_valid & head.we;
   assign fwd_wn    = out_valid ? head.wn   : '0;
   assign fwd_data  = out_valid ? head.data : '0;

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Directed bench for mem_wb_pipe: a 32-bit instance for handshake, load and
// flush behaviour, and a 64-bit instance for the wide load lanes.
module tb_mem_wb_pipe;
   import mem_wb_pipe_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        in_valid, in_ready, flush, out_valid, out_ready;
   logic [31:0] rd_in, alu_in, wb_data, fwd_data;
   logic [4:0]  wn_in, wb_wn, fwd_wn;
   logic        reg_write_in, mem_to_reg_in, ld_unsigned_in;
   logic [1:0]  ld_size_in;
   logic        wb_we, fwd_valid;
   occ_t        state;

   logic        in_valid_64, in_ready_64, out_valid_64, out_ready_64;
   logic [63:0] rd_64, alu_64, wb_data_64, fwd_data_64;
   logic [4:0]  wb_wn_64, fwd_wn_64;
   logic        wb_we_64, fwd_valid_64;
   occ_t        state_64;

   int n_asserts = 0;
   int n_fail    = 0;

   mem_wb_pipe #(.DATA_W(32), .REG_AW(5), .ZERO_REG_HARD(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .rd_in(rd_in), .alu_in(alu_in), .wn_in(wn_in), .reg_write_in(reg_write_in),
      .mem_to_reg_in(mem_to_reg_in), .ld_size_in(ld_size_in),
      .ld_unsigned_in(ld_unsigned_in), .flush(flush), .out_valid(out_valid),
      .out_ready(out_ready), .wb_data(wb_data), .wb_wn(wb_wn), .wb_we(wb_we),
      .fwd_valid(fwd_valid), .fwd_wn(fwd_wn), .fwd_data(fwd_data), .state(state)
   );

   mem_wb_pipe #(.DATA_W(64), .REG_AW(5), .ZERO_REG_HARD(1'b1)) dut64 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_64), .in_ready(in_ready_64),
      .rd_in(rd_64), .alu_in(alu_64), .wn_in(wn_in), .reg_write_in(reg_write_in),
      .mem_to_reg_in(mem_to_reg_in), .ld_size_in(ld_size_in),
      .ld_unsigned_in(ld_unsigned_in), .flush(1'b0), .out_valid(out_valid_64),
      .out_ready(out_ready_64), .wb_data(wb_data_64), .wb_wn(wb_wn_64),
      .wb_we(wb_we_64), .fwd_valid(fwd_valid_64), .fwd_wn(fwd_wn_64),
      .fwd_data(fwd_data_64), .state(state_64)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One-cycle input attempt of an ALU-type instruction.
   task automatic push(input logic [31:0] alu, input logic [4:0] wn);
      alu_in = alu; wn_in = wn; reg_write_in = 1'b1; mem_to_reg_in = 1'b0;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic load32(input logic [31:0] addr, input logic [1:0] size, input logic uns);
      rd_in = 32'h80FF_7F01; alu_in = addr; wn_in = 5'd10;
      reg_write_in = 1'b1; mem_to_reg_in = 1'b1; ld_size_in = size; ld_unsigned_in = uns;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic load64(input logic [63:0] addr, input logic [1:0] size, input logic uns);
      rd_64 = 64'h8000_0001_0000_0002; alu_64 = addr; wn_in = 5'd11;
      reg_write_in = 1'b1; mem_to_reg_in = 1'b1; ld_size_in = size; ld_unsigned_in = uns;
      in_valid_64 = 1'b1;
      tick();
      in_valid_64 = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
      rd_in = '0; alu_in = '0; wn_in = '0; reg_write_in = 1'b0;
      mem_to_reg_in = 1'b0; ld_size_in = LD_W; ld_unsigned_in = 1'b0;
      in_valid_64 = 1'b0; out_ready_64 = 1'b1; rd_64 = '0; alu_64 = '0;

      repeat (2) tick();
      chk("reset_out_valid", out_valid, 0);
      chk("reset_in_ready", in_ready, 1);
      chk("reset_wb_data", wb_data, 0);
      chk("reset_wb_wn", wb_wn, 0);
      chk("reset_wb_we", wb_we, 0);
      chk("reset_fwd_valid", fwd_valid, 0);
      chk("reset_state", state, EMPTY);
      rst_n = 1'b1;
      tick();

      // Single ALU transfer, one-cycle latency.
      out_ready = 1'b1;
      push(32'h0000_1234, 5'd8);
      chk("alu_out_valid", out_valid, 1);
      chk("alu_wb_we", wb_we, 1);
      chk("alu_wb_wn", wb_wn, 8);
      chk("alu_wb_data", wb_data, 32'h0000_1234);
      chk("alu_fwd_valid", fwd_valid, 1);
      chk("alu_fwd_wn", fwd_wn, 8);
      chk("alu_fwd_data", fwd_data, 32'h0000_1234);

      // Back-to-back loads from rd_in = 0x80FF_7F01.
      load32(32'h3, LD_B, 1'b0); chk("lb_lane3", wb_data, 32'hFFFF_FF80);
      load32(32'h3, LD_B, 1'b1); chk("lbu_lane3", wb_data, 32'h0000_0080);
      load32(32'h2, LD_H, 1'b0); chk("lh_lane1", wb_data, 32'hFFFF_80FF);
      load32(32'h0, LD_H, 1'b1); chk("lhu_lane0", wb_data, 32'h0000_7F01);
      load32(32'h1, LD_B, 1'b0); chk("lb_lane1", wb_data, 32'h0000_007F);
      load32(32'h0, LD_B, 1'b0); chk("lb_lane0", wb_data, 32'h0000_0001);
      load32(32'h0, LD_W, 1'b0); chk("lw", wb_data, 32'h80FF_7F01);
      load32(32'h0, LD_D, 1'b0); chk("ld_as_word", wb_data, 32'h80FF_7F01);
      chk("load_wb_wn", wb_wn, 10);
      tick();
      chk("drain_out_valid", out_valid, 0);
      chk("drain_wb_data", wb_data, 0);

      // Backpressure: A and B accepted, C refused.
      out_ready = 1'b0;
      push(32'hA, 5'd1);
      chk("bp_ready_after_a", in_ready, 1);
      push(32'hB, 5'd2);
      chk("bp_ready_after_b", in_ready, 0);
      chk("bp_state_two", state, TWO);
      chk("bp_head_a", wb_data, 32'hA);
      chk("bp_no_we", wb_we, 0);
      chk("bp_fwd_valid", fwd_valid, 1);
      push(32'hC, 5'd3);
      chk("bp_c_refused_state", state, TWO);
      chk("bp_c_refused_head", wb_data, 32'hA);
      out_ready = 1'b1;
      #1;
      chk("bp_a_we", wb_we, 1);
      chk("bp_a_wn", wb_wn, 1);
      tick();
      chk("bp_b_data", wb_data, 32'hB);
      chk("bp_b_wn", wb_wn, 2);
      chk("bp_ready_back", in_ready, 1);
      tick();
      chk("bp_c_absent", out_valid, 0);

      // Flush while full with a concurrent in_valid.
      out_ready = 1'b0;
      push(32'hD, 5'd4);
      push(32'hE, 5'd5);
      chk("fl_full", state, TWO);
      alu_in = 32'hF; wn_in = 5'd6; in_valid = 1'b1; flush = 1'b1;
      tick();
      in_valid = 1'b0; flush = 1'b0;
      chk("fl_two_out_valid", out_valid, 0);
      chk("fl_two_in_ready", in_ready, 1);
      out_ready = 1'b1;
      tick();
      chk("fl_two_f_absent", out_valid, 0);

      // Flush in ONE drops an input that fires in the same cycle.
      out_ready = 1'b0;
      push(32'h10, 5'd6);
      alu_in = 32'h11; wn_in = 5'd6; in_valid = 1'b1; flush = 1'b1;
      tick();
      in_valid = 1'b0; flush = 1'b0;
      chk("fl_one_out_valid", out_valid, 0);
      tick();
      chk("fl_one_h_absent", out_valid, 0);

      // Flush alongside an output fire still writes back the head.
      push(32'h77, 5'd7);
      out_ready = 1'b1; flush = 1'b1;
      #1;
      chk("fl_out_we", wb_we, 1);
      chk("fl_out_wn", wb_wn, 7);
      tick();
      flush = 1'b0;
      chk("fl_out_empty", out_valid, 0);

      // Register 0 is never written or forwarded.
      out_ready = 1'b0;
      push(32'h55, 5'd0);
      chk("z_out_valid", out_valid, 1);
      chk("z_wb_data", wb_data, 32'h55);
      chk("z_fwd_valid", fwd_valid, 0);
      out_ready = 1'b1;
      #1;
      chk("z_wb_we", wb_we, 0);
      tick();

      // Asynchronous reset mid-transfer clears immediately.
      out_ready = 1'b0;
      push(32'h99, 5'd9);
      chk("ar_before", out_valid, 1);
      rst_n = 1'b0;
      #1;
      chk("ar_out_valid", out_valid, 0);
      chk("ar_wb_data", wb_data, 0);
      chk("ar_in_ready", in_ready, 1);
      chk("ar_state", state, EMPTY);
      tick();
      rst_n = 1'b1;
      tick();

      // 64-bit instance, rd = 0x8000_0001_0000_0002.
      load64(64'h4, LD_W, 1'b0); chk("w64_lw_upper", wb_data_64, 64'hFFFF_FFFF_8000_0001);
      load64(64'h4, LD_D, 1'b0); chk("w64_ld", wb_data_64, 64'h8000_0001_0000_0002);
      load64(64'h0, LD_W, 1'b1); chk("w64_lwu_lower", wb_data_64, 64'h0000_0000_0000_0002);
      load64(64'h6, LD_H, 1'b0); chk("w64_lh_lane3", wb_data_64, 64'hFFFF_FFFF_FFFF_8000);
      load64(64'h7, LD_B, 1'b1); chk("w64_lbu_lane7", wb_data_64, 64'h0000_0000_0000_0080);
      chk("w64_we", wb_we_64, 1);
      tick();
      chk("w64_drain", out_valid_64, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
